icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have no parameters; geometry is fixed by cpu_types_pkg constants (16 frames, 1-word blocks).
REQ-002 SHALL have the port CLK  in  1  single system clock, all state on rising edge.
REQ-003 SHALL have the port nRST  in  1  asynchronous, active-low reset.
REQ-004 SHALL have the port imemREN  in  1  datapath instruction read request.
REQ-005 SHALL have the port imemaddr  in  32  instruction byte address.
REQ-006 SHALL have the port ihit  out  1  imemload valid this cycle.
REQ-007 SHALL have the port imemload  out  32  instruction word.
REQ-008 SHALL have the port iREN  out  1  fill request to memory_control.
REQ-009 SHALL have the port iaddr  out  32  word-aligned fill address to memory_control.
REQ-010 SHALL have the port iwait  in  1  memory_control stall, 1 = fill not complete.
REQ-011 SHALL have the port iload  in  32  fill data, valid when iwait=0.

Function
REQ-012 SHALL split the address as tag=[31:6] (26b), idx=[5:2] (4b), bytoff=[1:0] (ignored).
REQ-013 SHALL hold 16 frames, each with valid, 26b tag and 32b data.
REQ-014 SHALL assert ihit combinationally when state=IDLE, imemREN=1, valid[idx]=1 and tag matches: zero-cycle hit latency.
REQ-015 SHALL drive imemload=frame data when ihit=1 and 32'h0 otherwise.
REQ-016 SHALL use exactly two states, IDLE and FETCH.
REQ-017 SHALL go IDLE->FETCH on the edge where imemREN=1 and a miss occurs, latching {imemaddr[31:2],2'b00} into a miss-address register.
REQ-018 SHALL drive iREN=1 and iaddr=miss-address in FETCH, and iREN=0, iaddr=0 in IDLE.
REQ-019 SHALL, in FETCH with iwait=0, write the frame at the latched idx (valid=1, latched tag, data=iload) and return to IDLE on the same edge.
REQ-020 SHALL give no fill bypass: ihit first asserts the cycle after the fill edge, so miss latency = 1 + (iwait-high cycles) + 1.
REQ-021 SHALL complete a started fill to the latched address even if imemaddr changes or imemREN drops during FETCH.
REQ-022 SHALL hold ihit=0 throughout FETCH.
REQ-023 SHALL overwrite a valid frame whose idx matches and tag differs (direct-mapped conflict), with no write-back.
REQ-024 SHALL treat addresses differing only in bytoff as the same word.

Reset
REQ-025 SHALL, with nRST=0, force state=IDLE, clear all valid bits, clear miss-address, and drop iREN/ihit immediately, without waiting for CLK.
REQ-026 SHALL abandon an in-flight fill on reset mid-FETCH, leaving no frame written.
REQ-027 SHALL leave frame tag/data contents don't-care after reset; only valid is reset.

Configuration
REQ-028 SHALL, with ICACHE_STATS_EN defined, add outputs hitcnt[31:0] and misscnt[31:0], both reset to 0.
REQ-029 SHALL increment hitcnt on each cycle ihit=1 and misscnt on each IDLE->FETCH transition, both saturating at 32'hFFFFFFFF.
REQ-030 SHALL, with ICACHE_STATS_EN undefined, have neither the counter ports nor the counter logic, and identical behaviour otherwise.

Structure
REQ-031 SHALL take word_t, the icachef_t address struct (tag/idx/bytoff), the frame struct and the ITAG_W=26/IIDX_W=4 constants from cpu_types_pkg.
REQ-032 SHALL keep the state enum local to the module.
REQ-033 SHALL have no sub-module; the frame array is inline.

Verification
REQ-034 SHALL check cold miss: after reset, imemREN=1 and imemaddr=0x00000000 -> next cycle iREN=1, iaddr=0x0; iwait=1 for 4 cycles, then 0 with iload=0x20010004 -> the following cycle ihit=1, imemload=0x20010004, iREN=0.
REQ-035 SHALL check hit: re-read 0x00000003 -> ihit=1 in the same cycle, imemload=0x20010004, iREN never asserted.
REQ-036 SHALL check conflict: read 0x00000040 (idx0, tag1) -> miss and fill; then read 0x00000000 -> misses again.
REQ-037 SHALL check address change mid-fetch: miss at 0x08, switch imemaddr to 0x0C while iwait=1 -> iaddr stays 0x08, frame 2 filled, then new miss issued for 0x0C.
REQ-038 SHALL check reset mid-FETCH: nRST=0 while iREN=1 -> iREN=0 before the next CLK edge; after release, read 0x0 misses.
REQ-039 SHALL check counters with ICACHE_STATS_EN: two cold misses plus three single-cycle hits -> misscnt=2, hitcnt=5 (each miss yields one hit cycle after fill).

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg -- shared CPU types and cache geometry constants.
//   word_t          : 32-bit machine word
//   icachef_t       : instruction address split into tag / idx / bytoff
//   icache_frame_t  : one instruction-cache frame (valid, tag, data)
//   ITAG_W / IIDX_W : tag and index widths of the 16-frame, 1-word-block icache
package cpu_types_pkg;

    localparam int WORD_W  = 32;
    localparam int ITAG_W  = 26;
    localparam int IIDX_W  = 4;
    localparam int IBYT_W  = 2;
    localparam int IFRAMES = 1 << IIDX_W;

    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [IBYT_W-1:0] bytoff;
    } icachef_t;

    typedef struct packed {
        logic              valid;
        logic [ITAG_W-1:0] tag;
        word_t             data;
    } icache_frame_t;

endpackage

// File: rtl/icache.sv
// icache -- direct-mapped instruction cache, 16 frames of one word each.
//
// Ports
//   CLK       in   system clock, all state on the rising edge
//   nRST      in   asynchronous active-low reset
//   imemREN   in   datapath instruction read request
//   imemaddr  in   instruction byte address
//   ihit      out  imemload valid this cycle (zero-cycle hit)
//   imemload  out  instruction word, 0 when ihit=0
//   iREN      out  fill request to memory_control
//   iaddr     out  word-aligned fill address, 0 when idle
//   iwait     in   memory_control stall, 1 = fill not complete
//   iload     in   fill data, valid when iwait=0
//   hitcnt    out  (ICACHE_STATS_EN only) saturating count of hit cycles
//   misscnt   out  (ICACHE_STATS_EN only) saturating count of misses
//
// Build option: define ICACHE_STATS_EN to add the hit/miss counters.
module icache
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hitcnt,
    output logic [31:0] misscnt
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t   state_reg;
    state_t   state_next;
    icachef_t miss_addr_reg;
    icachef_t miss_addr_next;

    logic [IFRAMES-1:0] valid_reg;
    logic [ITAG_W-1:0]  tag_mem  [IFRAMES];
    word_t              data_mem [IFRAMES];

    icachef_t      req;
    icache_frame_t rd_frame;
    logic          fill_done;
    logic          miss_start;

    // Byte offset never selects anything: one-word blocks.
    logic unused_bytoff;
    assign unused_bytoff = ^req.bytoff;

    assign req = icachef_t'(imemaddr);

    // The frame array is read combinationally so a hit returns data in the
    // same cycle the request is presented.
    always_comb begin
        rd_frame.valid = valid_reg[req.idx];
        rd_frame.tag   = tag_mem[req.idx];
        rd_frame.data  = data_mem[req.idx];
    end

    assign fill_done = (state_reg == FETCH) && !iwait;

    // Next state and outputs. ihit is gated by IDLE, so it stays low for the
    // whole fill and only rises the cycle after the frame is written.
    always_comb begin
        state_next     = state_reg;
        miss_addr_next = miss_addr_reg;
        ihit           = 1'b0;
        imemload       = '0;
        iREN           = 1'b0;
        iaddr          = '0;
        miss_start     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (imemREN) begin
                    if (rd_frame.valid && (rd_frame.tag == req.tag)) begin
                        ihit     = 1'b1;
                        imemload = rd_frame.data;
                    end else begin
                        miss_start     = 1'b1;
                        state_next     = FETCH;
                        miss_addr_next = icachef_t'({imemaddr[31:2], 2'b00});
                    end
                end
            end
            FETCH: begin
                // The fill is committed to the latched address; imemREN and
                // imemaddr are ignored until it completes.
                iREN  = 1'b1;
                iaddr = miss_addr_reg;
                if (!iwait) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg     <= IDLE;
            miss_addr_reg <= '0;
        end else begin
            state_reg     <= state_next;
            miss_addr_reg <= miss_addr_next;
        end
    end

    // Per-frame valid bits are the only frame state that is reset; a reset
    // mid-fill clears the state register before any fill edge can occur.
    genvar gi;
    generate
        for (gi = 0; gi < IFRAMES; gi++) begin : g_valid
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    valid_reg[gi] <= 1'b0;
                end else if (fill_done && (miss_addr_reg.idx == gi[IIDX_W-1:0])) begin
                    valid_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    // Tag and data carry no reset; a conflicting line is simply overwritten.
    always_ff @(posedge CLK) begin
        if (fill_done) begin
            tag_mem[miss_addr_reg.idx]  <= miss_addr_reg.tag;
            data_mem[miss_addr_reg.idx] <= iload;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hitcnt_reg;
    logic [31:0] misscnt_reg;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hitcnt_reg  <= '0;
            misscnt_reg <= '0;
        end else begin
            if (ihit && (hitcnt_reg != 32'hFFFF_FFFF)) begin
                hitcnt_reg <= hitcnt_reg + 32'd1;
            end
            if (miss_start && (misscnt_reg != 32'hFFFF_FFFF)) begin
                misscnt_reg <= misscnt_reg + 32'd1;
            end
        end
    end

    assign hitcnt  = hitcnt_reg;
    assign misscnt = misscnt_reg;
`endif

endmodule

// File: tb/tb_icache.sv
// tb_icache -- self-checking bench for icache. A behavioural model keeps the
// set of resident word addresses (evicting any other address sharing the same
// word index on a fill) and a lazily populated backing memory.
module tb_icache;

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
`ifdef ICACHE_STATS_EN
    logic [31:0] hitcnt;
    logic [31:0] misscnt;
`endif

    icache dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
`ifdef ICACHE_STATS_EN
        ,
        .hitcnt   (hitcnt),
        .misscnt  (misscnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [int unsigned];
    logic [31:0] resident [$];

    function automatic logic [31:0] get_mem(input logic [31:0] wa);
        if (!mem.exists(wa)) mem[wa] = $urandom;
        return mem[wa];
    endfunction

    function automatic bit model_hit(input logic [31:0] wa);
        foreach (resident[i]) if (resident[i] == wa) return 1'b1;
        return 1'b0;
    endfunction

    // Word addresses map to frame (wa / 4) mod 16; only one may be resident.
    function automatic void model_fill(input logic [31:0] wa);
        for (int i = resident.size() - 1; i >= 0; i--)
            if (((resident[i] / 4) % 16) == ((wa / 4) % 16)) resident.delete(i);
        resident.push_back(wa);
    endfunction

    // One read transaction. Entered and left at posedge+1. With keep=1 the
    // task returns right after the fill edge, leaving imemREN=1 and
    // imemaddr=alt so the caller can observe what follows.
    task automatic do_read(input logic [31:0] a, input int waits,
                           input bit use_alt, input logic [31:0] alt, input bit keep);
        logic [31:0] wa;
        bit          exp_hit;
        wa       = a & 32'hFFFF_FFFC;
        imemREN  = 1'b1;
        imemaddr = a;
        iwait    = 1'b1;
        iload    = 32'h0;
        #1;
        exp_hit = model_hit(wa);
        total++;
        if (ihit !== exp_hit) begin
            bad++;
            $display("FAIL lookup addr=%h ihit=%b expected=%b", a, ihit, exp_hit);
        end
        total++;
        if (iREN !== 1'b0) begin
            bad++;
            $display("FAIL idle_iren addr=%h iREN=%b expected=0", a, iREN);
        end
        if (exp_hit) begin
            total++;
            if (imemload !== get_mem(wa)) begin
                bad++;
                $display("FAIL hit_data addr=%h imemload=%h expected=%h", a, imemload, get_mem(wa));
            end
            @(posedge CLK); #1;
            imemREN = 1'b0;
            $display("read addr=%h hit data=%h", a, imemload);
            return;
        end
        @(posedge CLK); #1;
        for (int k = 0; k <= waits; k++) begin
            if (use_alt) imemaddr = alt;
            if (k == waits) begin
                iwait = 1'b0;
                iload = get_mem(wa);
            end
            #1;
            total++;
            if (iREN !== 1'b1 || iaddr !== wa || ihit !== 1'b0) begin
                bad++;
                $display("FAIL fetch addr=%h iREN=%b iaddr=%h ihit=%b expected iREN=1 iaddr=%h ihit=0",
                         a, iREN, iaddr, ihit, wa);
            end
            @(posedge CLK); #1;
        end
        iwait = 1'b1;
        model_fill(wa);
        if (keep) begin
            $display("read addr=%h miss filled, keeping addr=%h", a, alt);
            return;
        end
        imemaddr = a;
        #1;
        total++;
        if (ihit !== 1'b1 || imemload !== get_mem(wa) || iREN !== 1'b0) begin
            bad++;
            $display("FAIL after_fill addr=%h ihit=%b imemload=%h iREN=%b expected ihit=1 imemload=%h iREN=0",
                     a, ihit, imemload, iREN, get_mem(wa));
        end
        @(posedge CLK); #1;
        imemREN = 1'b0;
        $display("read addr=%h miss waits=%0d data=%h", a, waits, get_mem(wa));
    endtask

    task automatic apply_reset();
        nRST = 1'b0;
        #1;
        resident.delete();
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        nRST     = 1'b0;
        imemREN  = 1'b1;
        imemaddr = 32'h0;
        iwait    = 1'b1;
        iload    = 32'h0;
        #2;
        total++;
        if (ihit !== 1'b0 || iREN !== 1'b0 || iaddr !== 32'h0 || imemload !== 32'h0) begin
            bad++;
            $display("FAIL reset ihit=%b iREN=%b iaddr=%h imemload=%h expected all 0",
                     ihit, iREN, iaddr, imemload);
        end
        imemREN = 1'b0;
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(posedge CLK); #1;
        $display("reset checked");
    endtask

    task automatic test_cold_miss_and_hit();
        mem[32'h0] = 32'h2001_0004;
        do_read(32'h0000_0000, 4, 1'b0, 32'h0, 1'b0);
        do_read(32'h0000_0003, 0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_conflict();
        do_read(32'h0000_0040, 1, 1'b0, 32'h0, 1'b0);
        do_read(32'h0000_0000, 0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_addr_change();
        do_read(32'h0000_0008, 2, 1'b1, 32'h0000_000C, 1'b1);
        #1;
        total++;
        if (ihit !== 1'b0 || iREN !== 1'b0) begin
            bad++;
            $display("FAIL addr_change_idle ihit=%b iREN=%b expected 0 0", ihit, iREN);
        end
        @(posedge CLK); #1;
        total++;
        if (iREN !== 1'b1 || iaddr !== 32'h0000_000C) begin
            bad++;
            $display("FAIL addr_change_refetch iREN=%b iaddr=%h expected 1 0000000c", iREN, iaddr);
        end
        iwait = 1'b0;
        iload = get_mem(32'h0000_000C);
        @(posedge CLK); #1;
        iwait   = 1'b1;
        imemREN = 1'b0;
        model_fill(32'h0000_000C);
        $display("addr change: second miss 0000000c issued and filled");
        do_read(32'h0000_0008, 0, 1'b0, 32'h0, 1'b0);
        do_read(32'h0000_000E, 0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_reset_mid_fetch();
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0014;
        @(posedge CLK); #1;
        total++;
        if (iREN !== 1'b1) begin
            bad++;
            $display("FAIL rst_fetch_entry iREN=%b expected 1", iREN);
        end
        nRST = 1'b0;
        #1;
        total++;
        if (iREN !== 1'b0 || ihit !== 1'b0 || iaddr !== 32'h0) begin
            bad++;
            $display("FAIL rst_async iREN=%b ihit=%b iaddr=%h expected 0 0 0", iREN, ihit, iaddr);
        end
        resident.delete();
        imemREN = 1'b0;
        iwait   = 1'b0;
        @(posedge CLK); #1;
        nRST  = 1'b1;
        iwait = 1'b1;
        @(posedge CLK); #1;
        $display("reset mid-fetch applied");
        do_read(32'h0000_0000, 1, 1'b0, 32'h0, 1'b0);
        do_read(32'h0000_0014, 0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            do_read(a, $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom, 1'b0);
            repeat ($urandom_range(0, 1)) begin
                @(posedge CLK); #1;
            end
        end
    endtask

`ifdef ICACHE_STATS_EN
    task automatic test_stats();
        apply_reset();
        total++;
        if (hitcnt !== 32'd0 || misscnt !== 32'd0) begin
            bad++;
            $display("FAIL stats_reset hitcnt=%0d misscnt=%0d expected 0 0", hitcnt, misscnt);
        end
        do_read(32'h0000_0100, 1, 1'b0, 32'h0, 1'b0);
        do_read(32'h0000_0204, 2, 1'b0, 32'h0, 1'b0);
        do_read(32'h0000_0100, 0, 1'b0, 32'h0, 1'b0);
        do_read(32'h0000_0206, 0, 1'b0, 32'h0, 1'b0);
        do_read(32'h0000_0101, 0, 1'b0, 32'h0, 1'b0);
        total++;
        if (hitcnt !== 32'd5 || misscnt !== 32'd2) begin
            bad++;
            $display("FAIL stats_count hitcnt=%0d misscnt=%0d expected 5 2", hitcnt, misscnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_cold_miss_and_hit();
        test_conflict();
        test_addr_change();
        test_reset_mid_fetch();
        test_random();
`ifdef ICACHE_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
